// File: rtl/serial_add_sequencer.sv
// Bit-serial adder sequencer: feeds an external single-bit full adder LSB first
// and assembles the result. Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cy_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cy_in,
  input  logic             fa_sum,
  input  logic             fa_cy_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cy_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] part_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sum_cat;
  logic             last_bit;

  // The partial register holds the bits received so far; the final bit
  // arrives straight from the adder, so the output register never sees a partial sum.
  assign sum_cat  = {fa_sum, part_sr};
  assign last_bit = (count == CW'(WIDTH - 1));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    fa_a     = 1'b0;
    fa_b     = 1'b0;
    fa_cy_in = 1'b0;
    if (state == SHIFT) begin
      fa_a     = a_sr[0];
      fa_b     = b_sr[0];
      fa_cy_in = carry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      part_sr <= '0;
      carry   <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cy_out  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr    <= op_a;
            b_sr    <= op_b;
            carry   <= cy_in;
            count   <= '0;
            part_sr <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          part_sr <= sum_cat[WIDTH-1:1];
          carry   <= fa_cy_out;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          count   <= count + CW'(1);
          if (last_bit) begin
            sum    <= sum_cat;
            cy_out <= fa_cy_out;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= carry ^ fa_cy_out;
`endif
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: a cycle-level arithmetic model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_serial_add_sequencer;

  localparam int WIDTH = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] op_a  = '0;
  logic [WIDTH-1:0] op_b  = '0;
  logic             cy_in = 1'b0;
  logic             fa_a, fa_b, fa_cy_in, fa_sum, fa_cy_out;
  logic             busy, done, cy_out;
  logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .cy_in     (cy_in),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cy_in  (fa_cy_in),
    .fa_sum    (fa_sum),
    .fa_cy_out (fa_cy_out),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cy_out    (cy_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  single_bit_full_adder u_fa (
    .a      (fa_a),
    .b      (fa_b),
    .cy_in  (fa_cy_in),
    .sum    (fa_sum),
    .cy_out (fa_cy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_cnt = cycles elapsed since the accepted start (0 = idle).
  int               m_cnt = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_sum = '0;
  logic             m_cin = 1'b0, m_cy = 1'b0, m_ovf = 1'b0;

  function automatic logic signed_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (s > (2 ** (WIDTH - 1)) - 1) || (s < -(2 ** (WIDTH - 1)));
  endfunction

  function automatic logic bit_of(input logic [WIDTH-1:0] v, input int cnt);
    if (cnt < 1 || cnt > WIDTH) return 1'b0;
    return v[cnt-1];
  endfunction

  // Carry flowing into bit k is the carry out of the low k bits' sum.
  function automatic logic carry_into(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic c, input int cnt);
    int k, mask, s;
    if (cnt < 1 || cnt > WIDTH) return 1'b0;
    k    = cnt - 1;
    mask = (1 << k) - 1;
    s    = (int'(a) & mask) + (int'(b) & mask) + int'(c);
    return 1'((s >> k) & 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_a   <= '0;
      m_b   <= '0;
      m_cin <= 1'b0;
      m_sum <= '0;
      m_cy  <= 1'b0;
      m_ovf <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt <= 1;
        m_a   <= op_a;
        m_b   <= op_b;
        m_cin <= cy_in;
      end
    end else if (m_cnt == WIDTH) begin
      m_cnt         <= WIDTH + 1;
      {m_cy, m_sum} <= (WIDTH + 1)'(m_a) + (WIDTH + 1)'(m_b) + (WIDTH + 1)'(m_cin);
      m_ovf         <= signed_ovf(m_a, m_b, m_cin);
    end else if (m_cnt == WIDTH + 1) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_cnt >= 1 && m_cnt <= WIDTH));
    check("done", 32'(done), 32'(m_cnt == WIDTH + 1));
    check("sum", 32'(sum), 32'(m_sum));
    check("cy_out", 32'(cy_out), 32'(m_cy));
    check("fa_a", 32'(fa_a), 32'(bit_of(m_a, m_cnt)));
    check("fa_b", 32'(fa_b), 32'(bit_of(m_b, m_cnt)));
    check("fa_cy_in", 32'(fa_cy_in), 32'(carry_into(m_a, m_b, m_cin, m_cnt)));
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", 32'(ovf), 32'(m_ovf));
`endif
  end

  // ---------------- directed stimulus ----------------
  // poke: cycle number (1 = first SHIFT cycle) in which a stray start with op_a=0x01 is driven.
  task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                         input logic [WIDTH-1:0] exp_sum, input logic exp_cy,
                         input logic exp_ovf, input int poke);
    int done_cycle, done_cnt;
    done_cycle = 0;
    done_cnt   = 0;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    cy_in = c;
    start = 1'b1;
    for (int n = 1; n <= WIDTH + 5; n++) begin
      @(negedge clk);
      start = (n == poke);
      if (n == poke) op_a = 8'h01;
      if (done) begin
        done_cnt++;
        if (done_cycle == 0) done_cycle = n;
      end
    end
    check("done_cycle", 32'(done_cycle), 32'(WIDTH + 1));
    check("done_count", 32'(done_cnt), 32'd1);
    check("sum_literal", 32'(sum), 32'(exp_sum));
    check("cy_literal", 32'(cy_out), 32'(exp_cy));
`ifdef SERIAL_ADD_OVF_EN
    check("ovf_literal", 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unexpected unknown overflow expectation");
`endif
  endtask

  initial begin
    int done_seen;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cy", 32'(cy_out), 32'd0);

    run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 4);
    run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, WIDTH + 1);
    run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    run_add(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 0);
    run_add(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    run_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);
    run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);

    // Abort an operation with reset during cycle 5 of SHIFT.
    @(negedge clk);
    op_a  = 8'h5A;
    op_b  = 8'h3C;
    cy_in = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_fa_a", 32'(fa_a), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    done_seen = 0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// Combinational single-bit full adder used as the downstream stage.
module single_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cy_in,
  output logic sum,
  output logic cy_out
);
  assign sum    = a ^ b ^ cy_in;
  assign cy_out = (a & b) | (a & cy_in) | (b & cy_in);
endmodule
